card_list_append: RTL

//  Appends one card to a singly linked card list held in the shared 1024x32 card RAM.

---
 rtl/card_mem_pkg.sv | 36 +++
 rtl/card_node_pack.sv | 29 ++
 rtl/card_list_append.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/card_mem_pkg.sv
// Shared card RAM node layout, field offsets and the append FSM state encoding.
package card_mem_pkg;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CARD_W   = 8;
  localparam int unsigned HDR_W    = 14;

  localparam int unsigned NEXT_LSB = 0;
  localparam int unsigned CARD_LSB = 10;
  localparam int unsigned HDR_LSB  = 18;

  localparam logic [ADDR_W-1:0] NULL_ADDR = 10'd0;
  // Header of a freshly written node: used=1, reserved bits clear
  localparam logic [HDR_W-1:0]  HDR_USED  = 14'h2000;

  typedef struct packed {
    logic              used;
    logic [12:0]       rsvd;
    logic [CARD_W-1:0] card;
    logic [ADDR_W-1:0] next;
  } node_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_W_ADDR  = 4'd1,
    S_W_WAIT  = 4'd2,
    S_W_CHECK = 4'd3,
    S_ALLOC   = 4'd4,
    S_WR_NODE = 4'd5,
    S_LINK    = 4'd6,
    S_FIN     = 4'd7,
    S_FAIL    = 4'd8
  } state_e;

endpackage

// File: rtl/card_node_pack.sv
// Combinational pack of node fields into a RAM word and unpack of a RAM word into fields.
module card_node_pack
  import card_mem_pkg::*;
(
  input  logic [HDR_W-1:0]  pack_hdr,
  input  logic [CARD_W-1:0] pack_card,
  input  logic [ADDR_W-1:0] pack_next,
  output logic [DATA_W-1:0] pack_word_c,
  input  logic [DATA_W-1:0] unpack_word,
  output logic [HDR_W-1:0]  unpack_hdr_c,
  output logic [CARD_W-1:0] unpack_card_c,
  output logic [ADDR_W-1:0] unpack_next_c
);

  node_t node;

  always_comb begin
    node.used = pack_hdr[HDR_W-1];
    node.rsvd = pack_hdr[HDR_W-2:0];
    node.card = pack_card;
    node.next = pack_next;
  end

  assign pack_word_c   = node;
  assign unpack_hdr_c  = unpack_word[DATA_W-1:HDR_LSB];
  assign unpack_card_c = unpack_word[HDR_LSB-1:CARD_LSB];
  assign unpack_next_c = unpack_word[CARD_LSB-1:NEXT_LSB];

endmodule

// File: rtl/card_list_append.sv
// Appends one card node to the tail of a linked list held in the shared card RAM.
// Optional CARD_LIST_DUP_CHECK_EN aborts when the card is already present in the list.
module card_list_append
  import card_mem_pkg::*;
#(
  parameter int unsigned MAX_NODES     = 1000,
  parameter int unsigned ALLOC_TIMEOUT = 2048
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [9:0]  head_addr,
  input  logic [7:0]  card,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [9:0]  new_head,
  output logic        alloc_req,
  input  logic        alloc_ack,
  input  logic [9:0]  alloc_addr,
  output logic        ram_owner,
  output logic [9:0]  ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q
);

  localparam int unsigned HOP_W = $clog2(MAX_NODES + 1);
  localparam int unsigned TMR_W = $clog2(ALLOC_TIMEOUT + 1);

  state_e state, state_d;

  logic [ADDR_W-1:0] head_q, cur_q, tail_q, nptr_q;
  logic [CARD_W-1:0] card_q, tail_card_q;
  logic [HDR_W-1:0]  tail_hdr_q;
  logic [HOP_W-1:0]  hops_q;
  logic [TMR_W-1:0]  timer_q;

  logic [HDR_W-1:0]  pack_hdr;
  logic [CARD_W-1:0] pack_card;
  logic [ADDR_W-1:0] pack_next;
  logic [DATA_W-1:0] pack_word_c;
  logic [HDR_W-1:0]  q_hdr_c;
  logic [CARD_W-1:0] q_card_c;
  logic [ADDR_W-1:0] q_next_c;

  logic dup_hit_c, hop_limit_c, alloc_expired_c;

  logic              busy_d, done_d, error_d, alloc_req_d, ram_owner_d, ram_wren_d;
  logic [ADDR_W-1:0] new_head_d, ram_address_d;
  logic [DATA_W-1:0] ram_data_d;

  card_node_pack u_node_pack (
    .pack_hdr      (pack_hdr),
    .pack_card     (pack_card),
    .pack_next     (pack_next),
    .pack_word_c   (pack_word_c),
    .unpack_word   (ram_q),
    .unpack_hdr_c  (q_hdr_c),
    .unpack_card_c (q_card_c),
    .unpack_next_c (q_next_c)
  );

`ifdef CARD_LIST_DUP_CHECK_EN
  assign dup_hit_c = (q_card_c == card_q);
`else
  assign dup_hit_c = 1'b0;
`endif

  assign hop_limit_c     = ((hops_q + HOP_W'(1)) == HOP_W'(MAX_NODES));
  assign alloc_expired_c = (timer_q == TMR_W'(ALLOC_TIMEOUT - 1));

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (start) state_d = (head_addr == NULL_ADDR) ? S_ALLOC : S_W_ADDR;
      S_W_ADDR:  state_d = S_W_WAIT;
      S_W_WAIT:  state_d = S_W_CHECK;
      S_W_CHECK: begin
        if (dup_hit_c)                  state_d = S_FAIL;
        else if (q_next_c == NULL_ADDR) state_d = S_ALLOC;
        else if (hop_limit_c)           state_d = S_FAIL;
        else                            state_d = S_W_ADDR;
      end
      S_ALLOC: begin
        if (alloc_ack)            state_d = S_WR_NODE;
        else if (alloc_expired_c) state_d = S_FAIL;
      end
      S_WR_NODE: state_d = (head_q == NULL_ADDR) ? S_FIN : S_LINK;
      S_LINK:    state_d = S_FIN;
      S_FIN:     state_d = S_IDLE;
      S_FAIL:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Word to write: new node, or old tail relinked to the new node
  always_comb begin
    pack_hdr  = HDR_USED;
    pack_card = card_q;
    pack_next = NULL_ADDR;
    if (state_d == S_LINK) begin
      pack_hdr  = tail_hdr_q;
      pack_card = tail_card_q;
      pack_next = nptr_q;
    end
  end

  // Output logic keyed on the state being entered, so registered outputs line up with it
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_FIN) || (state_d == S_FAIL);
    error_d       = (state_d == S_FAIL);
    alloc_req_d   = (state_d == S_ALLOC);
    ram_owner_d   = (state_d == S_W_ADDR) || (state_d == S_W_WAIT) || (state_d == S_W_CHECK) ||
                    (state_d == S_WR_NODE) || (state_d == S_LINK);
    ram_wren_d    = (state_d == S_WR_NODE) || (state_d == S_LINK);
    new_head_d    = new_head;
    ram_address_d = ram_address;
    ram_data_d    = ram_data;
    case (state_d)
      S_W_ADDR:  ram_address_d = (state == S_IDLE) ? head_addr : q_next_c;
      S_WR_NODE: begin
        ram_address_d = alloc_addr;
        ram_data_d    = pack_word_c;
      end
      S_LINK: begin
        ram_address_d = tail_q;
        ram_data_d    = pack_word_c;
      end
      S_FIN:     new_head_d = (head_q == NULL_ADDR) ? nptr_q : head_q;
      default:   ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      alloc_req   <= 1'b0;
      ram_owner   <= 1'b0;
      ram_wren    <= 1'b0;
      new_head    <= '0;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      alloc_req   <= alloc_req_d;
      ram_owner   <= ram_owner_d;
      ram_wren    <= ram_wren_d;
      new_head    <= new_head_d;
      ram_address <= ram_address_d;
      ram_data    <= ram_data_d;
    end
  end

  // Walk / allocation datapath
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q      <= '0;
      card_q      <= '0;
      cur_q       <= '0;
      hops_q      <= '0;
      timer_q     <= '0;
      tail_q      <= '0;
      tail_hdr_q  <= '0;
      tail_card_q <= '0;
      nptr_q      <= '0;
    end else begin
      timer_q <= (state == S_ALLOC) ? timer_q + TMR_W'(1) : '0;
      if (state == S_IDLE && start) begin
        head_q <= head_addr;
        card_q <= card;
        cur_q  <= head_addr;
        hops_q <= '0;
      end
      if (state == S_W_CHECK) begin
        if (q_next_c == NULL_ADDR) begin
          tail_q      <= cur_q;
          tail_hdr_q  <= q_hdr_c;
          tail_card_q <= q_card_c;
        end else begin
          cur_q  <= q_next_c;
          hops_q <= hops_q + HOP_W'(1);
        end
      end
      if (state == S_ALLOC && alloc_ack) nptr_q <= alloc_addr;
    end
  end

endmodule
